// File: rtl/bcd_axi_lite_conv.sv
// AXI4-Lite slave: scratch registers plus a sequential double-dabble binary-to-BCD converter.
// Converter control/status, operand and result are memory mapped; irq flags conversion completion.
module bcd_axi_lite_conv #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_USER_REGS      = 4,
  parameter int unsigned BIN_WIDTH          = 16,
  parameter int unsigned BCD_DIGITS         = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE_ST} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     acc_q, acc_d, adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 done_set_c;

  logic                 done_q, ovf_q, irq_en_q;
  logic [DW-1:0]        bin_q, bin_new;
  logic [DW-1:0]        user_q [NUM_USER_REGS];

  logic                 awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [DW-1:0]        rdata_q;

  logic                 wr_fire, rd_fire;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 wr_ctrl, wr_stat, wr_bin, wr_user, wr_err;
  logic                 start_c, start_go, w1c_done;
  logic [DW-1:0]        rd_data_c;
  logic                 rd_err_c;
  logic                 unused_ok;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(SW); b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write decode; the register update happens on the AW/W handshake edge
  assign wr_fire  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign wr_idx   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_ctrl  = wr_fire && (wr_idx == IDX_W'(0));
  assign wr_stat  = wr_fire && (wr_idx == IDX_W'(1));
  assign wr_bin   = wr_fire && (wr_idx == IDX_W'(2));
  assign wr_user  = (32'(wr_idx) >= 32'd4) && (32'(wr_idx) < 32'(NUM_USER_REGS + 4));
  assign wr_err   = (32'(wr_idx) > 32'd3) && !wr_user;
  assign start_c  = wr_ctrl & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign start_go = start_c && (state_q == IDLE);
  assign w1c_done = wr_stat & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
  assign bin_new  = merge(bin_q, S_AXI_WDATA, S_AXI_WSTRB);

  assign rd_fire  = arready_q & S_AXI_ARVALID;
  assign rd_idx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Converter FSM: add-3 on digits >= 5, then shift in the next operand MSB
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    done_set_c = 1'b0;
    adj        = acc_q;
    for (int k = 0; k < int'(BCD_DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = SHIFT;
          shift_d = bin_q[BIN_WIDTH-1:0];
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        acc_d   = {adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
        shift_d = {shift_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        // Result lands with the last shift so DONE is visible in the DONE_ST cycle
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d    = DONE_ST;
          bcd_d      = {adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
          done_set_c = 1'b1;
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // Register bank; a DONE set outranks a same-cycle clear
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      bin_q    <= '0;
      for (int i = 0; i < int'(NUM_USER_REGS); i++) user_q[i] <= '0;
    end else begin
      if (done_set_c) done_q <= 1'b1;
      else if (start_go || w1c_done) done_q <= 1'b0;
      if (wr_ctrl && S_AXI_WSTRB[0]) irq_en_q <= S_AXI_WDATA[1];
      if (wr_bin) begin
        bin_q <= bin_new;
        ovf_q <= |bin_new[DW-1:BIN_WIDTH];
      end
      for (int i = 0; i < int'(NUM_USER_REGS); i++) begin
        if (wr_fire && (32'(wr_idx) == 32'(i + 4))) user_q[i] <= bin_merge_user(i);
      end
    end
  end

  function automatic logic [DW-1:0] bin_merge_user(input int i);
    return merge(user_q[i], S_AXI_WDATA, S_AXI_WSTRB);
  endfunction

  // Read mux
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    case (rd_idx)
      IDX_W'(0): rd_data_c = DW'({irq_en_q, 1'b0});
      IDX_W'(1): rd_data_c = DW'({ovf_q, done_q, state_q == SHIFT});
      IDX_W'(2): rd_data_c = bin_q;
      IDX_W'(3): rd_data_c = DW'(bcd_q);
      default: begin
        rd_err_c = 1'b1;
        for (int i = 0; i < int'(NUM_USER_REGS); i++) begin
          if (32'(rd_idx) == 32'(i + 4)) begin
            rd_data_c = user_q[i];
            rd_err_c  = 1'b0;
          end
        end
      end
    endcase
  end

  // AXI handshake registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_c;
        rresp_q  <= rd_err_c ? 2'b10 : 2'b00;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign irq           = done_q & irq_en_q;

endmodule
